// File: rtl/mem_access_pkg.sv
// mem_access_pkg: access-size encodings and address-map helpers shared by the memory-access stage
package mem_access_pkg;
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    localparam int CH_W = 32;

    function automatic int mmio_end(input int n_in, input int n_out);
        return n_in + n_out;
    endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: lane extract/extend for loads and lane merge for stores
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] data,
    input  logic [1:0]  lane,
    input  size_e       size,
    input  logic        zero_ext,
    output logic [31:0] load,
    output logic [31:0] merged
);
    logic [4:0]  shift;
    logic [31:0] lane_word;
    logic [31:0] mask;
    logic        byte_sign;
    logic        half_sign;

    // halfwords sit on 16-bit boundaries, so only lane[1] moves them
    assign shift     = (size == SZ_HALF) ? {lane[1], 4'b0000} : {lane, 3'b000};
    assign lane_word = word >> shift;
    assign byte_sign = ~zero_ext & lane_word[7];
    assign half_sign = ~zero_ext & lane_word[15];

    assign load = (size == SZ_BYTE) ? {{24{byte_sign}}, lane_word[7:0]} :
                  (size == SZ_HALF) ? {{16{half_sign}}, lane_word[15:0]} : word;

    assign mask = ((size == SZ_BYTE) ? 32'h0000_00ff :
                   (size == SZ_HALF) ? 32'h0000_ffff :
                   (size == SZ_WORD) ? 32'hffff_ffff : 32'h0000_0000) << shift;

    assign merged = (word & ~mask) | ((data << shift) & mask);
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: registered load/store stage with RAM, DMA input/output channels and fault detection
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int NUM_DMA_IN  = 1,
    parameter int NUM_DMA_OUT = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_valid,
    input  logic [31:0]                 i_address,
    input  logic [31:0]                 i_data,
    input  logic                        i_enable_read,
    input  logic                        i_enable_write,
    input  logic [1:0]                  i_size,
    input  logic                        i_unsigned,
    input  logic                        i_write_to_reg,
    input  logic [4:0]                  i_dst_reg,
    input  logic [CH_W*NUM_DMA_IN-1:0]  i_dma_in,
    output logic [31:0]                 o_data,
    output logic                        o_valid,
    output logic                        o_write_to_reg,
    output logic [4:0]                  o_dst_reg,
    output logic                        o_fault,
    output logic [CH_W*NUM_DMA_OUT-1:0] o_dma_out,
    output logic [NUM_DMA_OUT-1:0]      o_dma_out_we
);
    localparam int MMIO_END = mmio_end(NUM_DMA_IN, NUM_DMA_OUT);
    localparam int AW       = $clog2(DEPTH_WORDS);

    logic [31:0]            ram [DEPTH_WORDS];
    logic [31:0]            dma_reg [NUM_DMA_OUT];
    logic [31:0]            wi;
    logic [31:0]            old_word;
    logic [31:0]            load_word;
    logic [31:0]            merged;
    logic [1:0]             lane;
    logic [AW-1:0]          ram_idx;
    logic                   access;
    logic                   misaligned;
    logic                   out_of_range;
    logic                   fault;
    logic                   store;
    logic                   ram_we;
    logic [NUM_DMA_OUT-1:0] dma_we;
    size_e                  size;

    assign size         = size_e'(i_size);
    assign wi           = {2'b00, i_address[31:2]};
    assign lane         = i_address[1:0];
    assign ram_idx      = i_address[AW+1:2];
    assign access       = i_enable_read | i_enable_write;
    assign misaligned   = ((size == SZ_HALF) & lane[0]) | ((size == SZ_WORD) & (lane != 2'b00)) | (size == SZ_RSVD);
    assign out_of_range = wi >= DEPTH_WORDS;
    assign fault        = access & (misaligned | out_of_range);
    assign store        = i_valid & i_enable_write & ~fault & ~rst;
    assign ram_we       = store & (wi >= MMIO_END);

    // MMIO words override the RAM read; DMA-input stores simply find no target
    always_comb begin
        old_word = ram[ram_idx];
        dma_we   = '0;
        for (int k = 0; k < NUM_DMA_IN; k++)
            if (wi == k) old_word = i_dma_in[k*CH_W +: CH_W];
        for (int k = 0; k < NUM_DMA_OUT; k++)
            if (wi == NUM_DMA_IN + k) begin
                old_word  = dma_reg[k];
                dma_we[k] = store;
            end
    end

    mem_lane_align u_align (
        .word     (old_word),
        .data     (i_data),
        .lane     (lane),
        .size     (size),
        .zero_ext (i_unsigned),
        .load     (load_word),
        .merged   (merged)
    );

    always_ff @(posedge clk)
        if (ram_we) ram[ram_idx] <= merged;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_data         <= '0;
            o_valid        <= 1'b0;
            o_write_to_reg <= 1'b0;
            o_dst_reg      <= '0;
            o_fault        <= 1'b0;
            o_dma_out_we   <= '0;
            for (int k = 0; k < NUM_DMA_OUT; k++) dma_reg[k] <= '0;
        end else begin
            o_valid        <= i_valid;
            o_write_to_reg <= i_valid & i_write_to_reg & ~fault;
            o_fault        <= i_valid & fault;
            o_dma_out_we   <= dma_we;
            if (i_valid) begin
                o_data    <= !access ? i_address : fault ? 32'h0 : load_word;
                o_dst_reg <= i_dst_reg;
            end
            for (int k = 0; k < NUM_DMA_OUT; k++)
                if (dma_we[k]) dma_reg[k] <= merged;
        end
    end

    for (genvar g = 0; g < NUM_DMA_OUT; g++) begin : g_dma_out
        assign o_dma_out[g*CH_W +: CH_W] = dma_reg[g];
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized scoreboard bench against a flat byte-addressed memory model
module tb_mem_access_unit;
    localparam int DEPTH_WORDS = 128;
    localparam int NUM_DMA_IN  = 1;
    localparam int NUM_DMA_OUT = 2;
    localparam int MMIO_END    = NUM_DMA_IN + NUM_DMA_OUT;

    logic                        clk;
    logic                        rst;
    logic                        i_valid;
    logic [31:0]                 i_address;
    logic [31:0]                 i_data;
    logic                        i_enable_read;
    logic                        i_enable_write;
    logic [1:0]                  i_size;
    logic                        i_unsigned;
    logic                        i_write_to_reg;
    logic [4:0]                  i_dst_reg;
    logic [32*NUM_DMA_IN-1:0]    i_dma_in;
    logic [31:0]                 o_data;
    logic                        o_valid;
    logic                        o_write_to_reg;
    logic [4:0]                  o_dst_reg;
    logic                        o_fault;
    logic [32*NUM_DMA_OUT-1:0]   o_dma_out;
    logic [NUM_DMA_OUT-1:0]      o_dma_out_we;

    mem_access_unit #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .NUM_DMA_IN  (NUM_DMA_IN),
        .NUM_DMA_OUT (NUM_DMA_OUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_valid        (i_valid),
        .i_address      (i_address),
        .i_data         (i_data),
        .i_enable_read  (i_enable_read),
        .i_enable_write (i_enable_write),
        .i_size         (i_size),
        .i_unsigned     (i_unsigned),
        .i_write_to_reg (i_write_to_reg),
        .i_dst_reg      (i_dst_reg),
        .i_dma_in       (i_dma_in),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .o_write_to_reg (o_write_to_reg),
        .o_dst_reg      (o_dst_reg),
        .o_fault        (o_fault),
        .o_dma_out      (o_dma_out),
        .o_dma_out_we   (o_dma_out_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]               data;
        logic                      valid;
        logic                      wtr;
        logic                      fault;
        logic [4:0]                dst;
        logic [NUM_DMA_OUT-1:0]    we;
        logic [32*NUM_DMA_OUT-1:0] dout;
    } exp_t;

    exp_t                     q[$];
    exp_t                     m;
    logic [7:0]               space [4*DEPTH_WORDS];
    logic [31:0]              last_data;
    logic [4:0]               last_dst;
    logic [32*NUM_DMA_IN-1:0] din_next;
    int                       checks = 0;
    int                       errors = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // one access per cycle enters at the negedge, its result is checked 1 time unit after the next posedge
    initial forever begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            m = q.pop_front();
            chk("o_data", o_data, m.data);
            chk("o_valid", o_valid, m.valid);
            chk("o_write_to_reg", o_write_to_reg, m.wtr);
            chk("o_dst_reg", o_dst_reg, m.dst);
            chk("o_fault", o_fault, m.fault);
            chk("o_dma_out_we", o_dma_out_we, m.we);
            chk("o_dma_out", o_dma_out, m.dout);
        end
    end

    function automatic logic [7:0] byte_at(input int a);
        return (a / 4 < NUM_DMA_IN) ? i_dma_in[a*8 +: 8] : space[a];
    endfunction

    task automatic acc(input bit v, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input bit u, input bit wtr, input logic [4:0] dst, input bit r);
        exp_t        e;
        logic [31:0] val;
        logic [31:0] res;
        logic [31:0] wi;
        int          n;
        bit          flt;
        bit          act;
        @(negedge clk);
        rst = r; i_valid = v; i_enable_read = rd; i_enable_write = wr; i_address = a; i_data = d;
        i_size = sz; i_unsigned = u; i_write_to_reg = wtr; i_dst_reg = dst; i_dma_in = din_next;
        e.we = '0;
        if (r) begin
            for (int i = 4*NUM_DMA_IN; i < 4*MMIO_END; i++) space[i] = 8'h00;
            last_data = 0; last_dst = 0;
            e.valid = 0; e.wtr = 0; e.fault = 0;
        end else begin
            wi  = a >> 2;
            n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            act = rd || wr;
            flt = act && (sz == 2'd3 || (a % n) != 0 || wi >= DEPTH_WORDS);
            val = 0;
            if (act && !flt) begin
                for (int i = 0; i < n; i++) val[8*i +: 8] = byte_at(int'(a) + i);
                if (!u && n < 4 && val[8*n-1])
                    for (int i = 8*n; i < 32; i++) val[i] = 1'b1;
            end
            res = !act ? a : flt ? 32'h0 : val;
            if (v && wr && !flt && wi >= NUM_DMA_IN) begin
                for (int i = 0; i < n; i++) space[int'(a) + i] = d[8*i +: 8];
                if (wi < MMIO_END) e.we[wi - NUM_DMA_IN] = 1'b1;
            end
            e.valid = v; e.wtr = v && wtr && !flt; e.fault = v && flt;
            if (v) begin last_data = res; last_dst = dst; end
        end
        e.data = last_data;
        e.dst  = last_dst;
        for (int i = 0; i < 4*NUM_DMA_OUT; i++) e.dout[8*i +: 8] = space[4*NUM_DMA_IN + i];
        q.push_back(e);
    endtask

    task automatic ld(input logic [31:0] a, input logic [1:0] sz, input bit u);
        acc(1, 1, 0, a, 32'h0, sz, u, 1, 5'd7, 0);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        acc(1, 0, 1, a, d, sz, 0, 0, 5'd3, 0);
    endtask

    initial begin
        rst = 1; i_valid = 0; i_enable_read = 0; i_enable_write = 0; i_address = 0; i_data = 0;
        i_size = 0; i_unsigned = 0; i_write_to_reg = 0; i_dst_reg = 0; i_dma_in = 0; din_next = 0;
        last_data = 0; last_dst = 0;
        for (int i = 0; i < 4*DEPTH_WORDS; i++) space[i] = 8'h00;
        repeat (3) acc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int w = MMIO_END; w < DEPTH_WORDS; w++) st(32'(4*w), 32'h0, 2'd2);
        st(32'h40, 32'hDEAD_BEEF, 2'd2);
        ld(32'h40, 2'd2, 0);
        st(32'h40, 32'h0, 2'd2);
        st(32'h41, 32'h80, 2'd0);
        ld(32'h41, 2'd0, 0);
        ld(32'h41, 2'd0, 1);
        ld(32'h40, 2'd2, 0);
        st(32'(4*NUM_DMA_IN), 32'h1234_5678, 2'd2);
        acc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        din_next = 32'hCAFE_0001;
        ld(32'h0, 2'd2, 0);
        st(32'h0, 32'hFFFF_FFFF, 2'd2);
        ld(32'h0, 2'd1, 0);
        acc(1, 1, 0, 32'h43, 0, 2'd1, 0, 1, 5'd9, 0);
        acc(1, 1, 0, 32'h42, 0, 2'd2, 0, 1, 5'd9, 0);
        acc(1, 0, 1, 32'(4*DEPTH_WORDS), 32'h5555_AAAA, 2'd2, 0, 1, 5'd9, 0);
        acc(1, 1, 0, 32'h40, 0, 2'd3, 0, 1, 5'd9, 0);
        acc(1, 0, 0, 32'h1234, 0, 2'd2, 0, 1, 5'd5, 0);
        st(32'(4*NUM_DMA_IN + 6), 32'hABCD, 2'd1);
        acc(1, 1, 1, 32'(4*NUM_DMA_IN + 4), 32'h77, 2'd0, 1, 1, 5'd11, 0);
        acc(0, 1, 1, 32'h50, 32'h99, 2'd2, 0, 1, 5'd12, 0);
        ld(32'h50, 2'd2, 0);
        acc(1, 0, 1, 32'(4*NUM_DMA_IN), 32'h0BAD_F00D, 2'd2, 0, 1, 5'd4, 1);
        ld(32'(4*NUM_DMA_IN), 2'd2, 0);
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            for (int c = 0; c < NUM_DMA_IN; c++) din_next[32*c +: 32] = $urandom;
            a = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 4*DEPTH_WORDS + 7));
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 4*MMIO_END + 3));
            acc($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom), a, $urandom,
                2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 5'($urandom), $urandom_range(0, 99) == 0);
        end
        acc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
